// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash dispenser.
// Contents: FSM state enum, note denominations, motor_sel encodings, err_code values and a
// helper that picks the next cassette to feed from (50s first, then 20s, then 10s).
package atm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPlan,
    StReq,
    StWaitAck,
    StGap,
    StDone
  } state_e;

  localparam logic [6:0] Denom50 = 7'd50;
  localparam logic [6:0] Denom20 = 7'd20;
  localparam logic [6:0] Denom10 = 7'd10;

  localparam logic [1:0] Sel10 = 2'b00;
  localparam logic [1:0] Sel20 = 2'b01;
  localparam logic [1:0] Sel50 = 2'b10;

  localparam logic [1:0] ErrOk        = 2'b00;
  localparam logic [1:0] ErrBadAmount = 2'b01;
  localparam logic [1:0] ErrNoNotes   = 2'b10;
  localparam logic [1:0] ErrTimeout   = 2'b11;

  // Dispense order: all 50s, then all 20s, then all 10s.
  function automatic logic [1:0] next_sel(input logic any_50, input logic any_20);
    if (any_50) begin
      return Sel50;
    end else if (any_20) begin
      return Sel20;
    end
    return Sel10;
  endfunction

endpackage

// File: rtl/atm_note_planner.sv
// Combinational greedy note breakdown (50/20/10) bounded by the live cassette inventories.
// Ports:
//   amount            in  7      requested withdrawal value
//   cnt_50/20/10      in  CNT_W  notes available in each cassette
//   n50/n20/n10       out CNT_W  notes to feed from each cassette
//   ok                out 1      breakdown covers the whole amount
module atm_note_planner
  import atm_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic [6:0]       amount,
  input  logic [CNT_W-1:0] cnt_50,
  input  logic [CNT_W-1:0] cnt_20,
  input  logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] n50,
  output logic [CNT_W-1:0] n20,
  output logic [CNT_W-1:0] n10,
  output logic             ok
);

  // Worked in 32 bits so any CNT_W compares cleanly; every value stays below 128.
  int unsigned rem;
  int unsigned t50;
  int unsigned t20;
  int unsigned t10;

  always_comb begin
    rem = 32'(amount);
    t50 = rem / 32'(Denom50);
    if (t50 > 32'(cnt_50)) t50 = 32'(cnt_50);
    rem = rem - t50 * 32'(Denom50);
    t20 = rem / 32'(Denom20);
    if (t20 > 32'(cnt_20)) t20 = 32'(cnt_20);
    rem = rem - t20 * 32'(Denom20);
    t10 = rem / 32'(Denom10);
    if (t10 > 32'(cnt_10)) t10 = 32'(cnt_10);
    rem = rem - t10 * 32'(Denom10);
    // Each t is bounded by its inventory, so the casts below never lose bits.
    n50 = CNT_W'(t50);
    n20 = CNT_W'(t20);
    n10 = CNT_W'(t10);
    ok  = (rem == 0);
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser: validates a withdrawal, plans a greedy 50/20/10 breakdown against the
// cassette inventories and feeds notes one at a time over a motor req/ack handshake.
// Optional feature macro: ATM_DISP_TIMEOUT_EN adds an ack watchdog (TIMEOUT_CYC cycles).
// Ports:
//   clk, reset (synchronous, active-low)
//   start/amount  withdrawal request (IDLE only); refill reloads cassettes (IDLE only)
//   motor_req/motor_sel/motor_ack  note-feed handshake
//   busy, done, error, err_code    status back to the controller
//   cnt_50/cnt_20/cnt_10           live cassette inventories
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned INIT_50     = 8,
  parameter int unsigned INIT_20     = 16,
  parameter int unsigned INIT_10     = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       amount,
  input  logic             refill,
  input  logic             motor_ack,
  output logic             motor_req,
  output logic [1:0]       motor_sel,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cnt_50,
  output logic [CNT_W-1:0] cnt_20,
  output logic [CNT_W-1:0] cnt_10
);

  localparam logic [CNT_W-1:0] Init50 = CNT_W'(INIT_50);
  localparam logic [CNT_W-1:0] Init20 = CNT_W'(INIT_20);
  localparam logic [CNT_W-1:0] Init10 = CNT_W'(INIT_10);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  state_e           state_q;
  logic [6:0]       amount_q;
  logic [CNT_W-1:0] n50_q, n20_q, n10_q;
  logic [CNT_W-1:0] plan_50, plan_20, plan_10;
  logic             plan_ok;
  logic             notes_left;

  atm_note_planner #(
    .CNT_W (CNT_W)
  ) u_planner (
    .amount (amount_q),
    .cnt_50 (cnt_50),
    .cnt_20 (cnt_20),
    .cnt_10 (cnt_10),
    .n50    (plan_50),
    .n20    (plan_20),
    .n10    (plan_10),
    .ok     (plan_ok)
  );

  assign notes_left = (n50_q != '0) || (n20_q != '0) || (n10_q != '0);

`ifdef ATM_DISP_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
  logic [TmrW-1:0] tmr_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Outputs are registered and updated on the transition into the state they belong to,
  // so motor_req is already high during REQ and done is high during DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      amount_q  <= '0;
      n50_q     <= '0;
      n20_q     <= '0;
      n10_q     <= '0;
      motor_req <= 1'b0;
      motor_sel <= Sel10;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ErrOk;
      cnt_50    <= Init50;
      cnt_20    <= Init20;
      cnt_10    <= Init10;
`ifdef ATM_DISP_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            amount_q <= amount;
            err_code <= ErrOk;
            busy     <= 1'b1;
            state_q  <= StCheck;
          end else if (refill) begin
            cnt_50 <= Init50;
            cnt_20 <= Init20;
            cnt_10 <= Init10;
          end
        end
        StCheck: begin
          if (amount_q == 7'd0 || (amount_q % Denom10) != 7'd0) begin
            err_code <= ErrBadAmount;
            done     <= 1'b1;
            error    <= 1'b1;
            state_q  <= StDone;
          end else begin
            state_q <= StPlan;
          end
        end
        StPlan: begin
          if (!plan_ok) begin
            err_code <= ErrNoNotes;
            done     <= 1'b1;
            error    <= 1'b1;
            state_q  <= StDone;
          end else begin
            n50_q     <= plan_50;
            n20_q     <= plan_20;
            n10_q     <= plan_10;
            motor_req <= 1'b1;
            motor_sel <= next_sel(plan_50 != '0, plan_20 != '0);
            state_q   <= StReq;
          end
        end
        StReq: begin
`ifdef ATM_DISP_TIMEOUT_EN
          tmr_q   <= '0;
`endif
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          if (motor_ack) begin
            motor_req <= 1'b0;
            unique case (motor_sel)
              Sel50: begin
                n50_q  <= n50_q - One;
                cnt_50 <= cnt_50 - One;
              end
              Sel20: begin
                n20_q  <= n20_q - One;
                cnt_20 <= cnt_20 - One;
              end
              default: begin
                n10_q  <= n10_q - One;
                cnt_10 <= cnt_10 - One;
              end
            endcase
            state_q <= StGap;
          end
`ifdef ATM_DISP_TIMEOUT_EN
          else if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
            // Notes already fed stay deducted; the rest of the plan is abandoned.
            motor_req <= 1'b0;
            err_code  <= ErrTimeout;
            done      <= 1'b1;
            error     <= 1'b1;
            state_q   <= StDone;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
`endif
        end
        StGap: begin
          if (notes_left) begin
            motor_req <= 1'b1;
            motor_sel <= next_sel(n50_q != '0, n20_q != '0);
            state_q   <= StReq;
          end else begin
            done    <= 1'b1;
            error   <= (err_code != ErrOk);
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Scoreboard bench for atm_cash_dispenser: each withdrawal pushes its expected note sequence
// and its expected completion record; the ack responder and done monitor pop and compare.
module tb_atm_cash_dispenser;

  localparam int unsigned CntW    = 6;
  localparam int          Init50  = 8;
  localparam int          Init20  = 16;
  localparam int          Init10  = 32;
  localparam int unsigned Timeout = 255;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [6:0]      amount = '0;
  logic            refill = 1'b0;
  logic            motor_ack = 1'b0;
  logic            motor_req;
  logic [1:0]      motor_sel;
  logic            busy;
  logic            done;
  logic            error;
  logic [1:0]      err_code;
  logic [CntW-1:0] cnt_50, cnt_20, cnt_10;

  atm_cash_dispenser #(
    .CNT_W       (CntW),
    .INIT_50     (Init50),
    .INIT_20     (Init20),
    .INIT_10     (Init10),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .refill    (refill),
    .motor_ack (motor_ack),
    .motor_req (motor_req),
    .motor_sel (motor_sel),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .cnt_50    (cnt_50),
    .cnt_20    (cnt_20),
    .cnt_10    (cnt_10)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] err;
    int         c50;
    int         c20;
    int         c10;
  } res_t;

  logic [1:0] sel_q[$];
  res_t       res_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         ack_en   = 1'b1;
  int         m50 = Init50, m20 = Init20, m10 = Init10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ack responder: ack during the cycle after req rises, then expect the one-cycle gap.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && motor_req === 1'b1) begin
        if (sel_q.size() == 0) check("req_unexpected", 1, 0);
        else check("motor_sel", 32'(motor_sel), 32'(sel_q.pop_front()));
        @(negedge clk);
        check("req_held", 32'(motor_req), 1);
        motor_ack = 1'b1;
        @(negedge clk);
        motor_ack = 1'b0;
        check("gap_req_low", 32'(motor_req), 0);
      end
    end
  end

  // Done monitor: compare the completion record against the scoreboard.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          r = res_q.pop_front();
          check("err_code", 32'(err_code), 32'(r.err));
          check("error", 32'(error), 32'(r.err != 2'b00));
          check("cnt_50", 32'(cnt_50), r.c50);
          check("cnt_20", 32'(cnt_20), r.c20);
          check("cnt_10", 32'(cnt_10), r.c10);
        end
      end
    end
  end

  // mode 0: plain; 1: start+refill pulsed while busy; 2: refill together with start.
  task automatic run_txn(input int amt, input int mode);
    int   rem, a50, a20, a10, lat, cyc;
    res_t r;
    a50 = 0; a20 = 0; a10 = 0;
    if (amt == 0 || amt % 10 != 0) begin
      r.err = 2'b01;
      lat   = 2;
    end else begin
      rem = amt;
      while (rem >= 50 && a50 < m50) begin rem -= 50; a50++; end
      while (rem >= 20 && a20 < m20) begin rem -= 20; a20++; end
      while (rem >= 10 && a10 < m10) begin rem -= 10; a10++; end
      if (rem != 0) begin
        r.err = 2'b10;
        lat   = 3;
      end else begin
        r.err = 2'b00;
        for (int i = 0; i < a50; i++) sel_q.push_back(2'b10);
        for (int i = 0; i < a20; i++) sel_q.push_back(2'b01);
        for (int i = 0; i < a10; i++) sel_q.push_back(2'b00);
        m50 -= a50; m20 -= a20; m10 -= a10;
        lat = 3 * (a50 + a20 + a10) + 3;
      end
    end
    r.c50 = m50; r.c20 = m20; r.c10 = m10;
    res_q.push_back(r);

    @(negedge clk);
    start  = 1'b1;
    amount = 7'(amt);
    if (mode == 2) refill = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    refill = 1'b0;
    cyc    = 1;
    check("busy_after_start", 32'(busy), 1);
    while (done !== 1'b1 && cyc < 2000) begin
      if (mode == 1 && cyc == 5) begin
        start  = 1'b1;
        amount = 7'd10;
        refill = 1'b1;
      end else begin
        start  = 1'b0;
        refill = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start  = 1'b0;
    refill = 1'b0;
    check($sformatf("latency_%0d", amt), cyc, lat);
    @(negedge clk);
    check("idle_after_done", 32'(busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 32'(motor_req), 0);
    check({tag, "_sel"}, 32'(motor_sel), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_errcode"}, 32'(err_code), 0);
    check({tag, "_c50"}, 32'(cnt_50), Init50);
    check({tag, "_c20"}, 32'(cnt_20), Init20);
    check({tag, "_c10"}, 32'(cnt_10), Init10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m50 = Init50; m20 = Init20; m10 = Init10;
    sel_q.delete();
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;

    run_txn(120, 0);
    run_txn(35, 0);
    run_txn(0, 0);
    run_txn(127, 0);

    // Reset while waiting for an ack abandons the withdrawal without a done pulse.
    ack_en = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    amount = 7'd120;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (motor_req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    check("first_req_seen", 32'(motor_req), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b1;
    m50 = Init50; m20 = Init20; m10 = Init10;
    repeat (6) @(negedge clk);
    check("no_busy_after_reset", 32'(busy), 0);

    // Ack never returned.
    @(negedge clk);
    start  = 1'b1;
    amount = 7'd10;
`ifdef ATM_DISP_TIMEOUT_EN
    res_q.push_back('{err: 2'b11, c50: m50, c20: m20, c10: m10});
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("timeout_latency", cyc, Timeout + 4);
    @(negedge clk);
    check("timeout_req_low", 32'(motor_req), 0);
`else
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    check("hang_busy", 32'(busy), 1);
    check("hang_req", 32'(motor_req), 1);
`endif
    do_reset();
    reset  = 1'b1;
    ack_en = 1'b1;

    // Drain the cassettes; busy-time start/refill pulses must not disturb anything.
    repeat (4) run_txn(120, 1);
    repeat (2) run_txn(120, 0);
    repeat (2) run_txn(120, 0);
    run_txn(80, 0);
    run_txn(60, 0);

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m50 = Init50; m20 = Init20; m10 = Init10;
    check("refill_c50", 32'(cnt_50), Init50);
    check("refill_c10", 32'(cnt_10), Init10);
    run_txn(60, 0);
    run_txn(10, 2);

    repeat (4) @(negedge clk);
    check("sel_queue_empty", 32'(sel_q.size()), 0);
    check("res_queue_empty", 32'(res_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
